// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helpers for the chunked serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int nchunk(input int dw, input int ch);
    return dw / ch;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_add_chunk_add.sv
// chunk_add: combinational CHUNK-bit adder slice with carry in/out.
module chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/serial_add.sv
// serial_add: multi-cycle adder processing CHUNK bits per clock with a start/busy/done handshake.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int CHUNK     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 cout
);
  localparam int NCHUNK = nchunk(DATAWIDTH, CHUNK);
  localparam int CW = cnt_w(NCHUNK);
  state_t state, state_nxt;
  logic [DATAWIDTH-1:0] ar, br, acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic carry, co, last;
  logic [CHUNK-1:0] s;
  assign last = cnt == CW'(NCHUNK - 1);
  chunk_add #(.CHUNK(CHUNK)) u_add (
    .x (ar[CHUNK-1:0]),
    .y (br[CHUNK-1:0]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  // New chunk enters at the top so the LSB chunk ends up at bit 0 after NCHUNK shifts
  assign acc_nxt = (acc >> CHUNK) | (DATAWIDTH'(s) << (DATAWIDTH - CHUNK));
  always_ff @(posedge Clk) begin
    if (!Rst) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == S_RUN ? (last ? S_DONE : S_RUN) : (start ? S_RUN : S_IDLE);
  end
  always_comb begin
    busy = state == S_RUN;
    done = state == S_DONE;
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ar    <= '0;
      br    <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == S_RUN) begin
      ar    <= ar >> CHUNK;
      br    <= br >> CHUNK;
      acc   <= acc_nxt;
      carry <= co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= acc_nxt;
        cout <= co;
      end
    end else if (start) begin
      ar    <= a;
      br    <= b;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end
  end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: scoreboard bench running CHUNK=2, 1 and 8 adders against a plain a+b model.
module tb_serial_add;
  logic Clk = 1'b0, Rst = 1'b0, start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] busy_w, done_w, cout_w;
  logic [7:0] sum_w [3];
  int lat [3] = '{4, 8, 1};
  typedef struct {
    int k;
    logic [8:0] r;
    int cyc;
  } exp_t;
  exp_t q[$];
  int cnt [3];
  logic [8:0] held [3];
  int cyc = 0, checks = 0, failures = 0;
  bit mon_on = 1'b0;
  serial_add #(.DATAWIDTH(8), .CHUNK(2)) u0 (.Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]));
  serial_add #(.DATAWIDTH(8), .CHUNK(1)) u1 (.Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]));
  serial_add #(.DATAWIDTH(8), .CHUNK(8)) u2 (.Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]));
  always #5 Clk = ~Clk;
  // Reference: each adder is free when its model countdown is zero; result is plain a+b
  always @(posedge Clk) begin
    cyc++;
    if (!Rst) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        cnt[k]  = 0;
        held[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (start && cnt[k] == 0) begin
          q.push_back('{k, {1'b0, a} + {1'b0, b}, cyc + lat[k]});
          cnt[k] = lat[k];
        end else if (cnt[k] > 0) cnt[k]--;
      end
    end
  end
  function automatic int find(input int k);
    foreach (q[i]) if (q[i].k == k) return i;
    return -1;
  endfunction
  always @(negedge Clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = find(k);
        if (done_w[k]) begin
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL spurious_done inst=%0d cyc=%0d no pending result", k, cyc);
          end else begin
            if (q[idx].cyc != cyc) begin
              failures++;
              $display("FAIL done_latency inst=%0d got cyc=%0d want cyc=%0d", k, cyc, q[idx].cyc);
            end
            held[k] = q[idx].r;
            q.delete(idx);
          end
        end else if (idx >= 0 && q[idx].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_done inst=%0d cyc=%0d want cyc=%0d", k, cyc, q[idx].cyc);
          q.delete(idx);
        end
        checks++;
        if ({cout_w[k], sum_w[k]} !== held[k]) begin
          failures++;
          $display("FAIL result inst=%0d cyc=%0d got cout=%0b sum=%02h want cout=%0b sum=%02h",
                   k, cyc, cout_w[k], sum_w[k], held[k][8], held[k][7:0]);
        end
        checks++;
        if (busy_w[k] !== (cnt[k] != 0)) begin
          failures++;
          $display("FAIL busy inst=%0d cyc=%0d got %0b want %0b", k, cyc, busy_w[k], cnt[k] != 0);
        end
      end
    end
  end
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    @(negedge Clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask
  initial begin
    @(negedge Clk);
    mon_on = 1'b1;
    @(negedge Clk);
    Rst = 1'b1;
    issue(8'd100, 8'd27);
    idle(10);
    issue(8'hFF, 8'h01);
    idle(10);
    issue(8'h0F, 8'h01);
    idle(10);
    issue(8'hAA, 8'h55);
    idle(10);
    issue(8'hFF, 8'h01);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    idle(12);
    issue(8'd3, 8'd4);
    a = 8'd77;
    b = 8'd88;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    idle(12);
    issue(8'h12, 8'h34);
    repeat (4) @(negedge Clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    idle(12);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] x, y;
      @(negedge Clk);
      x = 8'($urandom);
      y = 8'($urandom);
      a = $urandom_range(0, 1) == 0 ? x - y : x;
      b = y;
      start = $urandom_range(0, 1) == 1;
      Rst = $urandom_range(0, 299) != 0;
    end
    @(negedge Clk);
    Rst = 1'b1;
    start = 1'b0;
    idle(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
